// File: rtl/instr_loader_if.sv
// Bus between the serial instruction source / CPU core and instr_loader.
// master = source/core side, slave = loader side.
interface instr_loader_if;
  logic        ser_in;
  logic        ser_valid;
  logic        ser_start;
  logic        core_ready;
  logic [3:0]  opcode;
  logic [11:0] instr;
  logic        inst_done;
  logic        pending;
  logic        overrun;

  modport master (
    output ser_in,
    output ser_valid,
    output ser_start,
    output core_ready,
    input  opcode,
    input  instr,
    input  inst_done,
    input  pending,
    input  overrun
  );

  modport slave (
    input  ser_in,
    input  ser_valid,
    input  ser_start,
    input  core_ready,
    output opcode,
    output instr,
    output inst_done,
    output pending,
    output overrun
  );
endinterface

// File: rtl/instr_loader.sv
// Serial-to-parallel instruction loader with a one-word holding buffer,
// plus a synchronized, debounced push-button rising-edge detector.
module instr_loader #(
  parameter int DEBOUNCE = 4
) (
  input  logic           clk,
  input  logic           rstn,
  instr_loader_if.slave  bus,
  input  logic           btn_raw,
  output logic           btn_edge
);

  localparam int DCW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DCW-1:0] DLAST = DCW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    PEND  = 2'd1,
    ISSUE = 2'd2
  } state_t;

  // ---------------- serial assembly ----------------
  logic [15:0] sr_reg;
  logic [3:0]  cnt_reg;
  logic        bit_take;
  logic        word_done;
  logic [15:0] word;

  // ser_start masks ser_valid, so a restart on the 16th bit never completes a word
  assign bit_take  = bus.ser_valid && !bus.ser_start;
  assign word_done = bit_take && (cnt_reg == 4'd15);
  assign word      = {sr_reg[14:0], bus.ser_in};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr_reg  <= 16'h0000;
      cnt_reg <= 4'd0;
    end else if (bus.ser_start) begin
      sr_reg  <= 16'h0000;
      cnt_reg <= 4'd0;
    end else if (bus.ser_valid) begin
      sr_reg  <= word;
      cnt_reg <= cnt_reg + 4'd1;
    end
  end

  // ---------------- holding buffer FSM ----------------
  state_t      state_reg, state_next;
  logic [15:0] hold_reg, hold_next;
  logic [15:0] out_reg, out_next;
  logic        inst_done_reg, inst_done_next;
  logic        overrun_reg, overrun_next;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= EMPTY;
      hold_reg      <= 16'h0000;
      out_reg       <= 16'h0000;
      inst_done_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      hold_reg      <= hold_next;
      out_reg       <= out_next;
      inst_done_reg <= inst_done_next;
      overrun_reg   <= overrun_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    hold_next      = hold_reg;
    out_next       = out_reg;
    inst_done_next = 1'b0;
    overrun_next   = overrun_reg;
    case (state_reg)
      EMPTY: begin
        if (word_done) begin
          hold_next  = word;
          state_next = PEND;
        end
      end
      PEND: begin
        // buffer is full: a freshly completed word has nowhere to go
        if (word_done) begin
          overrun_next = 1'b1;
        end
        if (bus.core_ready) begin
          out_next       = hold_reg;
          inst_done_next = 1'b1;
          state_next     = ISSUE;
        end
      end
      ISSUE: begin
        if (word_done) begin
          hold_next  = word;
          state_next = PEND;
        end else begin
          state_next = EMPTY;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
  end

  assign bus.opcode    = out_reg[15:12];
  assign bus.instr     = out_reg[11:0];
  assign bus.inst_done = inst_done_reg;
  assign bus.pending   = (state_reg == PEND);
  assign bus.overrun   = overrun_reg;

  // ---------------- button path ----------------
  logic [1:0]     sync_reg;
  logic           btn_s;
  logic           deb_reg;
  logic [DCW-1:0] dcnt_reg;
  logic           btn_edge_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], btn_raw};
    end
  end

  assign btn_s = sync_reg[1];

  // a new level must survive DEBOUNCE consecutive cycles before deb follows it
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      deb_reg      <= 1'b0;
      dcnt_reg     <= '0;
      btn_edge_reg <= 1'b0;
    end else begin
      btn_edge_reg <= 1'b0;
      if (btn_s != deb_reg) begin
        if (dcnt_reg == DLAST) begin
          deb_reg      <= btn_s;
          dcnt_reg     <= '0;
          btn_edge_reg <= btn_s;
        end else begin
          dcnt_reg <= dcnt_reg + DCW'(1);
        end
      end else begin
        dcnt_reg <= '0;
      end
    end
  end

  assign btn_edge = btn_edge_reg;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: scoreboard of expected issued words,
// popped by a strobe monitor; button debounce timing checked cycle by cycle.
module tb_instr_loader;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic btn_raw = 1'b0;
  logic btn_edge;

  instr_loader_if bus ();

  instr_loader #(.DEBOUNCE(4)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .bus      (bus),
    .btn_raw  (btn_raw),
    .btn_edge (btn_edge)
  );

  always #5 clk = ~clk;

  int pass_cnt   = 0;
  int fail_cnt   = 0;
  int total_cnt  = 0;
  int strobe_cnt = 0;
  int edge_cnt   = 0;
  logic [15:0] sb[$];
  logic [15:0] exp_w;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // strobe monitor: every issued word must match the oldest expected entry
  always @(negedge clk) begin
    if (rstn && bus.inst_done) begin
      strobe_cnt++;
      if (sb.size() == 0) begin
        check("strobe_has_expected_entry", 32'(sb.size()), 32'd1);
      end else begin
        exp_w = sb.pop_front();
        $display("issue: opcode=%h instr=%h expected=%h", bus.opcode, bus.instr, exp_w);
        check("issued_word", {16'h0, bus.opcode, bus.instr}, {16'h0, exp_w});
      end
    end
    if (rstn && btn_edge) begin
      edge_cnt++;
      $display("btn_edge pulse #%0d", edge_cnt);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // send the top nbits of w, MSB first, one bit per cycle with no gaps
  task automatic send_bits(input logic [15:0] w, input int nbits);
    for (int i = 15; i > 15 - nbits; i--) begin
      bus.ser_in    = w[i];
      bus.ser_valid = 1'b1;
      step(1);
    end
    bus.ser_valid = 1'b0;
    bus.ser_in    = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step(2);
    rstn = 1'b1;
    step(1);
  endtask

  int s0;
  int e0;

  initial begin
    bus.ser_in     = 1'b0;
    bus.ser_valid  = 1'b0;
    bus.ser_start  = 1'b0;
    bus.core_ready = 1'b0;
    step(3);

    // reset values
    check("rst_opcode", bus.opcode, 0);
    check("rst_instr", bus.instr, 0);
    check("rst_inst_done", bus.inst_done, 0);
    check("rst_pending", bus.pending, 0);
    check("rst_overrun", bus.overrun, 0);
    check("rst_btn_edge", btn_edge, 0);
    rstn = 1'b1;
    step(1);

    // word with core ready: strobe two edges after the last bit
    bus.core_ready = 1'b1;
    s0 = strobe_cnt;
    sb.push_back(16'hA5C3);
    send_bits(16'hA5C3, 16);
    check("t1_no_strobe_at_last_bit", bus.inst_done, 0);
    check("t1_pending_at_last_bit", bus.pending, 1);
    step(1);
    check("t1_strobe", bus.inst_done, 1);
    check("t1_opcode", bus.opcode, 4'hA);
    check("t1_instr", bus.instr, 12'h5C3);
    step(1);
    check("t1_strobe_one_cycle", bus.inst_done, 0);
    check("t1_pending_after", bus.pending, 0);
    step(5);
    check("t1_opcode_held", bus.opcode, 4'hA);
    check("t1_instr_held", bus.instr, 12'h5C3);
    check("t1_strobe_count", strobe_cnt - s0, 1);
    check("t1_overrun", bus.overrun, 0);

    // core not ready: word waits in the buffer
    do_reset();
    bus.core_ready = 1'b0;
    s0 = strobe_cnt;
    sb.push_back(16'h1234);
    send_bits(16'h1234, 16);
    step(1);
    check("t2_pending", bus.pending, 1);
    check("t2_opcode_unchanged", bus.opcode, 0);
    check("t2_instr_unchanged", bus.instr, 0);
    step(9);
    check("t2_still_pending", bus.pending, 1);
    bus.core_ready = 1'b1;
    step(1);
    check("t2_strobe", bus.inst_done, 1);
    check("t2_opcode", bus.opcode, 4'h1);
    check("t2_instr", bus.instr, 12'h234);
    bus.core_ready = 1'b0;
    step(2);
    check("t2_pending_cleared", bus.pending, 0);
    check("t2_strobe_count", strobe_cnt - s0, 1);

    // overrun: second word dropped while the first is pending
    do_reset();
    bus.core_ready = 1'b0;
    s0 = strobe_cnt;
    sb.push_back(16'h1111);
    send_bits(16'h1111, 16);
    send_bits(16'h2222, 16);
    step(1);
    check("t3_overrun", bus.overrun, 1);
    check("t3_pending", bus.pending, 1);
    bus.core_ready = 1'b1;
    step(1);
    check("t3_strobe", bus.inst_done, 1);
    check("t3_opcode", bus.opcode, 4'h1);
    check("t3_instr", bus.instr, 12'h111);
    step(4);
    check("t3_overrun_sticky", bus.overrun, 1);
    check("t3_strobe_count", strobe_cnt - s0, 1);
    bus.core_ready = 1'b0;

    // back-to-back words with core ready
    do_reset();
    bus.core_ready = 1'b1;
    s0 = strobe_cnt;
    sb.push_back(16'h3333);
    sb.push_back(16'h4444);
    send_bits(16'h3333, 16);
    send_bits(16'h4444, 16);
    step(1);
    check("t4_strobe2", bus.inst_done, 1);
    check("t4_opcode", bus.opcode, 4'h4);
    check("t4_instr", bus.instr, 12'h444);
    step(2);
    check("t4_strobe_count", strobe_cnt - s0, 2);
    check("t4_no_overrun", bus.overrun, 0);

    // frame restart after a partial word
    do_reset();
    s0 = strobe_cnt;
    send_bits(16'hFF80, 9);
    bus.ser_start = 1'b1;
    step(1);
    bus.ser_start = 1'b0;
    sb.push_back(16'hF00F);
    send_bits(16'hF00F, 16);
    step(1);
    check("t5_strobe", bus.inst_done, 1);
    check("t5_opcode", bus.opcode, 4'hF);
    check("t5_instr", bus.instr, 12'h00F);
    step(3);
    check("t5_strobe_count", strobe_cnt - s0, 1);

    // restart arriving with the 16th bit wins
    s0 = strobe_cnt;
    send_bits(16'hFFFF, 15);
    bus.ser_in    = 1'b1;
    bus.ser_valid = 1'b1;
    bus.ser_start = 1'b1;
    step(1);
    bus.ser_valid = 1'b0;
    bus.ser_start = 1'b0;
    step(3);
    check("t5b_no_pending", bus.pending, 0);
    check("t5b_no_strobe", strobe_cnt - s0, 0);
    sb.push_back(16'h0F0F);
    send_bits(16'h0F0F, 16);
    step(1);
    check("t5b_opcode", bus.opcode, 4'h0);
    check("t5b_instr", bus.instr, 12'hF0F);
    step(2);

    // reset while pending discards the held word
    s0 = strobe_cnt;
    bus.core_ready = 1'b0;
    send_bits(16'h5A5A, 16);
    step(1);
    check("t6_pending_before_rst", bus.pending, 1);
    rstn = 1'b0;
    step(1);
    check("t6_pending_in_rst", bus.pending, 0);
    check("t6_opcode_in_rst", bus.opcode, 0);
    rstn = 1'b1;
    bus.core_ready = 1'b1;
    step(5);
    check("t6_no_strobe", strobe_cnt - s0, 0);

    // reset mid-frame discards the partial word
    send_bits(16'hC3C3, 8);
    rstn = 1'b0;
    step(1);
    rstn = 1'b1;
    step(1);
    send_bits(16'hC3C3, 8);
    step(4);
    check("t7_no_strobe", strobe_cnt - s0, 0);
    check("t7_pending", bus.pending, 0);
    bus.core_ready = 1'b0;

    // 3-cycle glitch is filtered
    e0 = edge_cnt;
    btn_raw = 1'b1;
    step(3);
    btn_raw = 1'b0;
    step(10);
    check("b1_glitch_no_edge", edge_cnt - e0, 0);

    // held press: one pulse registered on edge 6
    e0 = edge_cnt;
    btn_raw = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      if (k == 5) check("b2_edge_not_early", btn_edge, 0);
      if (k == 6) check("b2_edge_on_edge6", btn_edge, 1);
      if (k == 7) check("b2_edge_one_cycle", btn_edge, 0);
    end
    btn_raw = 1'b0;
    step(12);
    check("b2_single_pulse_no_release_pulse", edge_cnt - e0, 1);
    check("b2_btn_edge_low", btn_edge, 0);

    // reset mid-debounce
    e0 = edge_cnt;
    btn_raw = 1'b1;
    step(4);
    rstn = 1'b0;
    step(1);
    check("b3_btn_edge_in_rst", btn_edge, 0);
    btn_raw = 1'b0;
    step(1);
    rstn = 1'b1;
    step(10);
    check("b3_no_pulse", edge_cnt - e0, 0);

    check("scoreboard_drained", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
